fifo_seg_display: RTL and testbench

- 8-entry × 15-bit FIFO driven by a single active-low pushbutton and a mode switch, with four hex 7-segment digit outputs.
- Each button press performs one operation: a write (push) of datain when mode=1, or a read (pop) when mode=0.
- The last popped word is held and shown on the display.
- Top-level board block: button/switch inputs from pins, full/empty to LEDs, segments to display pins.

---
 rtl/fifo_seg_pkg.sv | 19 +
 rtl/hex_to_seg7.sv | 12 +
 rtl/fifo_seg_display.sv | 121 ++++++++++++
 tb/tb_fifo_seg_display.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_seg_pkg.sv
// Shared types and constants for the FIFO-to-seven-segment board block.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package fifo_seg_pkg;

  localparam int DEF_DATA_W   = 15;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_DEBOUNCE = 4;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [6:0]            seg_t;

  localparam seg_t SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// One hex nibble to an active-low seven-segment pattern.
// Purely combinational.
module hex_to_seg7
  import fifo_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg_t       o_seg
);

  assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/fifo_seg_display.sv
// Button-driven FIFO with the last popped word on four hex digits.
// Define DEBOUNCE_EN to require a stable button level before acting.
module fifo_seg_display
  import fifo_seg_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button,
  input  logic              mode,
  input  logic [DATA_W-1:0] datain,
  output logic              full,
  output logic              empty,
  output seg_t              segment4,
  output seg_t              segment3,
  output seg_t              segment2,
  output seg_t              segment1
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DATA_W > 16 || DATA_W < 1) begin : g_bad_w
    $error("DATA_W must be 1..16");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_d
    $error("DEPTH must be a power of two >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0] r_sync;
  logic       w_sync;
  logic       w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], button};
  end

  assign w_sync = r_sync[1];

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // r_stable flips only after the new level has held long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else if (w_sync == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= w_sync;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign w_press = r_stable & ~w_sync & (r_cnt == CNT_LAST);
`else
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b1;
    else        r_prev <= w_sync;
  end

  assign w_press = r_prev & ~w_sync;
`endif

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [DATA_W-1:0] r_display;
  logic              w_do_wr;
  logic              w_do_rd;
  logic [15:0]       w_disp16;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_wr = w_press &  mode & ~full;
  assign w_do_rd = w_press & ~mode & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= datain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_display <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) begin
        r_display <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign w_disp16 = 16'(r_display);

  hex_to_seg7 u_d4 (.i_hex(w_disp16[15:12]), .o_seg(segment4));
  hex_to_seg7 u_d3 (.i_hex(w_disp16[11:8]),  .o_seg(segment3));
  hex_to_seg7 u_d2 (.i_hex(w_disp16[7:4]),   .o_seg(segment2));
  hex_to_seg7 u_d1 (.i_hex(w_disp16[3:0]),   .o_seg(segment1));

endmodule

// File: tb/tb_fifo_seg_display.sv
// Directed bench for fifo_seg_display: push/pop via the button,
// flags and decoded digits checked against hand-computed values.
module tb_fifo_seg_display;

  logic        clk;
  logic        rst_n;
  logic        button;
  logic        mode;
  logic [14:0] datain;
  logic        full;
  logic        empty;
  logic [6:0]  segment4;
  logic [6:0]  segment3;
  logic [6:0]  segment2;
  logic [6:0]  segment1;

  int n_cmp;
  int n_bad;

  fifo_seg_display dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .button   (button),
    .mode     (mode),
    .datain   (datain),
    .full     (full),
    .empty    (empty),
    .segment4 (segment4),
    .segment3 (segment3),
    .segment2 (segment2),
    .segment1 (segment1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000; 4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100; 4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001; 4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010; 4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000; 4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000; 4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110; 4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110; default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic check_disp(input string tag, input logic [15:0] v);
    check({tag, ".seg4"}, 32'(segment4), 32'(seg_of(v[15:12])));
    check({tag, ".seg3"}, 32'(segment3), 32'(seg_of(v[11:8])));
    check({tag, ".seg2"}, 32'(segment2), 32'(seg_of(v[7:4])));
    check({tag, ".seg1"}, 32'(segment1), 32'(seg_of(v[3:0])));
  endtask

  // hold and release long enough for the debounced build as well
  task automatic press(input logic m, input logic [14:0] d);
    @(negedge clk);
    mode   = m;
    datain = d;
    button = 1'b0;
    repeat (10) @(negedge clk);
    button = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] exp_q [$];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    button = 1'b1;
    mode   = 1'b0;
    datain = '0;
    do_reset();

    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full", 32'(full), 32'd0);
    check("rst.seg4", 32'(segment4), 32'h40);
    check("rst.seg1", 32'(segment1), 32'h40);

    press(1'b1, 15'h7D00);
    check("w7d.empty", 32'(empty), 32'd0);
    press(1'b0, 15'h0);
    check("r7d.seg4", 32'(segment4), 32'b1111000);
    check("r7d.seg3", 32'(segment3), 32'b0100001);
    check("r7d.seg2", 32'(segment2), 32'b1000000);
    check("r7d.seg1", 32'(segment1), 32'b1000000);
    check("r7d.empty", 32'(empty), 32'd1);

    @(negedge clk);
    mode   = 1'b1;
    datain = 15'd1;
    button = 1'b0;
    repeat (8) @(negedge clk);
    button = 1'b1;
    repeat (10) @(negedge clk);
    check("hold.empty", 32'(empty), 32'd0);
    press(1'b0, 15'h0);
    check_disp("hold.rd", 16'h0001);
    check("hold.empty2", 32'(empty), 32'd1);

    for (int i = 1; i <= 8; i++) begin
      if (i == 8) check("fill7.full", 32'(full), 32'd0);
      press(1'b1, 15'(i));
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.empty", 32'(empty), 32'd0);
    press(1'b1, 15'd9);
    check("drop.full", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      press(1'b0, 15'h0);
      check_disp($sformatf("drain%0d", i), 16'(i));
      check("drain.full", 32'(full), 32'd0);
    end
    check("drain.empty", 32'(empty), 32'd1);
    press(1'b0, 15'h0);
    check_disp("rd9", 16'h0008);
    check("rd9.empty", 32'(empty), 32'd1);

    do_reset();
    press(1'b0, 15'h0);
    check_disp("rdemp", 16'h0000);
    check("rdemp.empty", 32'(empty), 32'd1);
    check("rdemp.full", 32'(full), 32'd0);
    press(1'b1, 15'h00AB);
    press(1'b0, 15'h0);
    check_disp("rdemp.ptr", 16'h00AB);
    check("rdemp.empty2", 32'(empty), 32'd1);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 15'(16'h0110 + i));
      exp_q.push_back(16'h0110 + 16'(i));
    end
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 15'h0);
      check_disp($sformatf("wrap.r%0d", i), exp_q.pop_front());
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("wrap7.full", 32'(full), 32'd0);
      press(1'b1, 15'(16'h4C20 + i));
      exp_q.push_back(16'h4C20 + 16'(i));
    end
    check("wrap.full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      press(1'b0, 15'h0);
      check_disp($sformatf("wrap.d%0d", i), exp_q.pop_front());
    end
    check("wrap.empty", 32'(empty), 32'd1);

    for (int i = 0; i < 4; i++) press(1'b1, 15'(16'h3E50 + i));
    press(1'b0, 15'h0);
    check_disp("mid.pre", 16'h3E50);
    check("mid.preempty", 32'(empty), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid.empty", 32'(empty), 32'd1);
    check("mid.full", 32'(full), 32'd0);
    check_disp("mid.disp", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    press(1'b0, 15'h0);
    check_disp("mid.rd", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
